// File: rtl/word18_framer_fifo_if.sv
// Bus bundle for the 18-bit framer FIFO: framed word input, flagged 16-bit output
// and the dropped-word error reporting.
interface word18_framer_fifo_if #(
    parameter int ERR_W = 8
);
    logic [17:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      out_data;
    logic             out_sof;
    logic             out_eof;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sof, out_eof, out_valid, frame_err, err_count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sof, out_eof, out_valid, frame_err, err_count
    );
endinterface

// File: rtl/word18_framer_fifo.sv
// First-word-fall-through FIFO for 18-bit framed words with a write-side framing
// checker. Words breaking SOF/EOF framing are accepted but discarded, so the
// output stream is always well-framed. Dropped words pulse frame_err and bump a
// saturating counter.
module word18_framer_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int ERR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    word18_framer_fifo_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ZERO = (AW+1)'(32'd0);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(32'd1);
    localparam logic [AW-1:0]    PTR_ZERO = AW'(32'd0);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(32'd1);
    localparam logic [ERR_W-1:0] ERR_ZERO = ERR_W'(32'd0);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(32'd1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    // Storage is deliberately not reset; occupancy is tracked by pointers/count.
    logic [17:0]      mem_q [DEPTH];

    state_t           state_q,     state_d;
    logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [AW:0]      count_q,     count_d;
    logic             frame_err_q, frame_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             pop_s;
    logic             store_s;
    logic             drop_s;
    logic             in_sof_s;
    logic             in_eof_s;
    logic [17:0]      head_s;

    // Handshake decode; in_ready depends on the registered count only.
    always_comb begin
        full_s   = (count_q == FULL_CNT);
        empty_s  = (count_q == CNT_ZERO);
        accept_s = bus.in_valid & ~full_s;
        pop_s    = bus.out_ready & ~empty_s;
        in_sof_s = bus.in_data[17];
        in_eof_s = bus.in_data[16];
        head_s   = mem_q[rd_ptr_q];
    end

    // Framing checker: decide store/drop for each accepted word and track frame state.
    always_comb begin
        state_d = state_q;
        store_s = 1'b0;
        drop_s  = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_sof_s) begin
                        store_s = 1'b1;
                        if (in_eof_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_IN_FRAME;
                        end
                    end else begin
                        drop_s = 1'b1;
                    end
                end
                ST_IN_FRAME: begin
                    if (in_sof_s) begin
                        // A stray SOF inside a frame is discarded; the frame continues.
                        drop_s = 1'b1;
                    end else begin
                        store_s = 1'b1;
                        if (in_eof_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_IN_FRAME;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO pointers, occupancy and error bookkeeping.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        frame_err_d = drop_s;
        err_count_d = err_count_q;

        if (store_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({store_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (drop_s && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            frame_err_q <= 1'b0;
            err_count_q <= ERR_ZERO;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Word storage, written only for words that passed the framing check.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = ~full_s;
    assign bus.out_valid = ~empty_s;
    assign bus.out_data  = empty_s ? 16'h0000 : head_s[15:0];
    assign bus.out_sof   = empty_s ? 1'b0     : head_s[17];
    assign bus.out_eof   = empty_s ? 1'b0     : head_s[16];
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;

endmodule
